// File: rtl/mul_pkg.sv
// Shared types and constants for the shift-add multiplier.
package mul_pkg;

  localparam int unsigned MUL_WIDTH = 32;
  localparam int unsigned COUNT_W   = $clog2(MUL_WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mul_sequencer_if.sv
// Start/busy/done handshake plus operand and result bus for mul_sequencer.
interface mul_sequencer_if
  import mul_pkg::*;
#(
  parameter int unsigned WIDTH = MUL_WIDTH
) ();

  logic                 start;
  logic [WIDTH-1:0]     multiplicand;
  logic [WIDTH-1:0]     multiplier;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;
  logic                 overflow;

  modport master (
    output start, multiplicand, multiplier,
    input  busy, done, product, overflow
  );

  modport slave (
    input  start, multiplicand, multiplier,
    output busy, done, product, overflow
  );

endinterface

// File: rtl/mul_datapath.sv
// Multiplicand and product registers with the (WIDTH+1)-bit adder and shift.
module mul_datapath
  import mul_pkg::*;
#(
  parameter int unsigned WIDTH = MUL_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic                 load_zero,
  input  logic                 step,
  input  logic                 add,
  input  logic                 finish,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic [2*WIDTH-1:0]   product,
  output logic                 overflow,
  output logic                 lsb
);

  logic [WIDTH-1:0]   mcand_reg;
  logic [WIDTH:0]     sum_c;
  logic [2*WIDTH-1:0] product_next_c;

  // Conditional add of the multiplicand into the upper half, then shift right
  always_comb begin
    sum_c = {1'b0, product[2*WIDTH-1:WIDTH]};
    if (add) begin
      sum_c = (WIDTH+1)'({1'b0, product[2*WIDTH-1:WIDTH]}) + (WIDTH+1)'({1'b0, mcand_reg});
    end
    product_next_c = {sum_c, product[WIDTH-1:1]};
  end

  assign lsb = product[0];

  // Operand capture, per-step update and overflow flag at the final step
  always_ff @(posedge clk) begin
    if (reset) begin
      mcand_reg <= '0;
      product   <= '0;
      overflow  <= 1'b0;
    end else if (load) begin
      mcand_reg <= multiplicand;
      product   <= load_zero ? '0 : {{WIDTH{1'b0}}, multiplier};
      overflow  <= 1'b0;
    end else if (step) begin
      product <= product_next_c;
      if (finish) begin
        overflow <= |product_next_c[2*WIDTH-1:WIDTH];
      end
    end
  end

endmodule

// File: rtl/mul_sequencer.sv
// Multi-cycle unsigned shift-add multiplier: control FSM, step counter and datapath.
// Optional build macro MUL_SEQUENCER_ZERO_SKIP_EN: a zero operand goes straight to DONE.
module mul_sequencer
  import mul_pkg::*;
#(
  parameter int unsigned WIDTH = MUL_WIDTH
) (
  input  logic            clk,
  input  logic            reset,
  mul_sequencer_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  localparam logic [1:0] IDLE = ST_IDLE;
  localparam logic [1:0] RUN  = ST_RUN;
  localparam logic [1:0] DONE = ST_DONE;

  logic [1:0]       state;
  logic [1:0]       state_next;
  logic [CNT_W-1:0] count;
  logic             last_c;
  logic             load_c;
  logic             load_zero_c;
  logic             step_c;
  logic             add_c;
  logic             finish_c;
  logic             lsb;

  assign last_c = (count == CNT_W'(WIDTH-1));

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode and datapath strobes
  always_comb begin
    state_next  = state;
    load_c      = 1'b0;
    load_zero_c = 1'b0;
    step_c      = 1'b0;
    add_c       = 1'b0;
    finish_c    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          load_c     = 1'b1;
          state_next = RUN;
`ifdef MUL_SEQUENCER_ZERO_SKIP_EN
          if ((bus.multiplicand == '0) || (bus.multiplier == '0)) begin
            load_zero_c = 1'b1;
            state_next  = DONE;
          end
`endif
        end
      end
      RUN: begin
        step_c = 1'b1;
        add_c  = lsb;
        if (last_c) begin
          finish_c   = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Step counter; holds at its final value instead of wrapping
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load_c) begin
      count <= '0;
    end else if (step_c && !last_c) begin
      count <= count + CNT_W'(1);
    end
  end

  // Registered handshake outputs, derived from the upcoming state
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
    end else begin
      bus.busy <= (state_next != IDLE);
      bus.done <= (state_next == DONE);
    end
  end

  mul_datapath #(
    .WIDTH (WIDTH)
  ) u_datapath (
    .clk          (clk),
    .reset        (reset),
    .load         (load_c),
    .load_zero    (load_zero_c),
    .step         (step_c),
    .add          (add_c),
    .finish       (finish_c),
    .multiplicand (bus.multiplicand),
    .multiplier   (bus.multiplier),
    .product      (bus.product),
    .overflow     (bus.overflow),
    .lsb          (lsb)
  );

endmodule
